// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
package ahb_pkg;

    localparam int PORT_NUM_DEF = 7;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } def_state_e;

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ transfers with the two-cycle ERROR response.
// ERR1 stalls the bus with HRESP=ERROR, ERR2 completes it; a new unmapped access in ERR2 restarts ERR1.
module ahblite_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADY,
    input  logic       HSEL,
    input  logic [1:0] HTRANS,
    output logic       HREADYOUT,
    output logic       HRESP
);

    def_state_e state_q, state_d;
    logic       start;
    logic       unused_htrans0;

    assign unused_htrans0 = HTRANS[0];
    assign start          = HREADY & HSEL & HTRANS[1];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            DS_IDLE: begin
                if (start) begin
                    state_d = DS_ERR1;
                end
            end
            DS_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = DS_ERR2;
            end
            DS_ERR2: begin
                HRESP   = HRESP_ERROR;
                state_d = start ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite data-phase response mux: latches the decoded select while HREADY is high
// and steers the chosen slave's (or the built-in default slave's) response to the master.
module ahblite_slave_mux
    import ahb_pkg::*;
#(
    parameter int             PORT_NUM  = PORT_NUM_DEF,
    parameter int             DW        = 32,
    parameter logic [DW-1:0]  ERR_RDATA = '0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HREADY,
    input  logic [1:0]             HTRANS,
    input  logic [PORT_NUM-1:0]    P_HSEL,
    input  logic [PORT_NUM-1:0]    P_HREADYOUT,
    input  logic [PORT_NUM-1:0]    P_HRESP,
    input  logic [PORT_NUM*DW-1:0] P_HRDATA,
    output logic                   HREADY_OUT,
    output logic                   HRESP,
    output logic [DW-1:0]          HRDATA
);

    localparam logic [PORT_NUM-1:0] ONE = {{(PORT_NUM-1){1'b0}}, 1'b1};

    logic [PORT_NUM:0]   sel_q, sel_d;
    logic [PORT_NUM-1:0] hsel_oh;
    logic                def_sel;
    logic                def_hreadyout;
    logic                def_hresp;
    logic                unused_htrans0;

    assign unused_htrans0 = HTRANS[0];
    assign def_sel        = (P_HSEL == '0);
    // x & -x keeps only the lowest set bit, so the lowest-numbered port wins.
    assign hsel_oh        = P_HSEL & (~P_HSEL + ONE);

    always_comb begin
        sel_d = sel_q;
        if (HREADY) begin
            sel_d = {def_sel & HTRANS[1], hsel_oh};
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    ahblite_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HREADY    (HREADY),
        .HSEL      (def_sel),
        .HTRANS    (HTRANS),
        .HREADYOUT (def_hreadyout),
        .HRESP     (def_hresp)
    );

    // AND-OR mux; an all-zero sel_q (no data phase) yields a ready OKAY with zero data.
    always_comb begin
        HREADY_OUT = ~(|sel_q) | (sel_q[PORT_NUM] & def_hreadyout);
        HRESP      = sel_q[PORT_NUM] & def_hresp;
        HRDATA     = {DW{sel_q[PORT_NUM]}} & ERR_RDATA;
        for (int i = 0; i < PORT_NUM; i++) begin
            HREADY_OUT = HREADY_OUT | (sel_q[i] & P_HREADYOUT[i]);
            HRESP      = HRESP | (sel_q[i] & P_HRESP[i]);
            HRDATA     = HRDATA | ({DW{sel_q[i]}} & P_HRDATA[i*DW +: DW]);
        end
    end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Directed bench for ahblite_slave_mux with HREADY_OUT fed back into HREADY.
module tb_ahblite_slave_mux;
    import ahb_pkg::*;

    localparam int PN = 7;
    localparam int DW = 32;

    logic           HCLK;
    logic           HRESET;
    logic           HREADY;
    logic [1:0]     HTRANS;
    logic [PN-1:0]  P_HSEL;
    logic [PN-1:0]  P_HREADYOUT;
    logic [PN-1:0]  P_HRESP;
    logic [PN*DW-1:0] P_HRDATA;
    logic           HREADY_OUT;
    logic           HRESP;
    logic [DW-1:0]  HRDATA;

    int checks   = 0;
    int failures = 0;

    assign HREADY = HREADY_OUT;

    ahblite_slave_mux #(.PORT_NUM(PN), .DW(DW), .ERR_RDATA(32'h0000_0000)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HREADY      (HREADY),
        .HTRANS      (HTRANS),
        .P_HSEL      (P_HSEL),
        .P_HREADYOUT (P_HREADYOUT),
        .P_HRESP     (P_HRESP),
        .P_HRDATA    (P_HRDATA),
        .HREADY_OUT  (HREADY_OUT),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_rdy, input logic e_resp,
                           input logic [31:0] e_dat);
        chk({tag, ".hready"}, {31'b0, HREADY_OUT}, {31'b0, e_rdy});
        chk({tag, ".hresp"},  {31'b0, HRESP},      {31'b0, e_resp});
        chk({tag, ".hrdata"}, HRDATA,              e_dat);
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_slot(input int idx, input logic [31:0] val);
        P_HRDATA[idx*DW +: DW] = val;
    endtask

    initial begin
        // Reset with random bus inputs
        HRESET      = 1'b1;
        HTRANS      = 2'($urandom);
        P_HSEL      = 7'($urandom);
        P_HREADYOUT = 7'($urandom);
        P_HRESP     = 7'($urandom);
        for (int i = 0; i < PN; i++) set_slot(i, $urandom);
        #2;
        chk_out("reset_t0", 1'b1, 1'b0, 32'h0);
        cyc();
        chk_out("reset_c1", 1'b1, 1'b0, 32'h0);
        cyc();
        chk_out("reset_c2", 1'b1, 1'b0, 32'h0);

        // Release with no transfer
        HTRANS      = HTRANS_IDLE;
        P_HSEL      = '0;
        P_HREADYOUT = '1;
        P_HRESP     = '0;
        for (int i = 0; i < PN; i++) set_slot(i, 32'hA5A5_0000 | i);
        #2;
        HRESET = 1'b0;
        cyc();
        chk_out("post_reset_idle", 1'b1, 1'b0, 32'h0);

        // Single read via P1; P3 drives a stray ERROR that must not leak
        P_HSEL  = 7'b0000010;
        HTRANS  = HTRANS_NONSEQ;
        P_HRESP = 7'b0001000;
        #1;
        chk_out("p1_addr_phase", 1'b1, 1'b0, 32'h0);
        cyc();
        P_HSEL = '0;
        HTRANS = HTRANS_IDLE;
        set_slot(1, 32'h1234_5678);
        #1;
        chk_out("p1_data", 1'b1, 1'b0, 32'h1234_5678);
        P_HRESP = '0;

        // Multiple selects: lowest index (P2) wins over P4 and P6
        cyc();
        P_HSEL = 7'b1010100;
        HTRANS = HTRANS_NONSEQ;
        cyc();
        P_HSEL = '0;
        HTRANS = HTRANS_IDLE;
        set_slot(2, 32'h2222_2222);
        set_slot(4, 32'h4444_0000);
        set_slot(6, 32'h6666_0000);
        P_HREADYOUT = 7'b0010000 ^ 7'h7F;
        #1;
        chk_out("multi_hsel_p2", 1'b1, 1'b0, 32'h2222_2222);
        P_HREADYOUT = '1;

        // Wait states on P2 while the decoder moves on to P4
        cyc();
        P_HSEL = 7'b0000100;
        HTRANS = HTRANS_NONSEQ;
        cyc();
        P_HSEL = 7'b0010000;
        P_HREADYOUT = 7'b1111011;
        set_slot(2, 32'hCAFE_0002);
        #1;
        chk_out("p2_wait1", 1'b0, 1'b0, 32'hCAFE_0002);
        cyc();
        chk_out("p2_wait2", 1'b0, 1'b0, 32'hCAFE_0002);
        cyc();
        chk_out("p2_wait3", 1'b0, 1'b0, 32'hCAFE_0002);
        cyc();
        P_HREADYOUT = '1;
        #1;
        chk_out("p2_done", 1'b1, 1'b0, 32'hCAFE_0002);
        cyc();
        P_HSEL = '0;
        HTRANS = HTRANS_IDLE;
        set_slot(4, 32'h4444_4444);
        #1;
        chk_out("p4_after_wait", 1'b1, 1'b0, 32'h4444_4444);

        // Unmapped NONSEQ: ERR1, ERR2, then OKAY; slaves all signal ERROR to catch leaks
        P_HRESP = '1;
        cyc();
        P_HSEL = '0;
        HTRANS = HTRANS_NONSEQ;
        #1;
        chk_out("unmapped_addr", 1'b1, 1'b0, 32'h0);
        cyc();
        HTRANS = HTRANS_IDLE;
        #1;
        chk_out("unmapped_err1", 1'b0, 1'b1, 32'h0);
        cyc();
        chk_out("unmapped_err2", 1'b1, 1'b1, 32'h0);
        cyc();
        chk_out("unmapped_okay", 1'b1, 1'b0, 32'h0);
        cyc();
        chk_out("unmapped_idle_zero_wait", 1'b1, 1'b0, 32'h0);
        HTRANS = HTRANS_BUSY;
        cyc();
        HTRANS = HTRANS_IDLE;
        #1;
        chk_out("unmapped_busy_zero_wait", 1'b1, 1'b0, 32'h0);

        // Back-to-back unmapped: no OKAY cycle between the two ERROR pairs
        HTRANS = HTRANS_NONSEQ;
        cyc();
        chk_out("b2b_err1_a", 1'b0, 1'b1, 32'h0);
        cyc();
        chk_out("b2b_err2_a", 1'b1, 1'b1, 32'h0);
        cyc();
        chk_out("b2b_err1_b", 1'b0, 1'b1, 32'h0);
        cyc();
        P_HSEL = 7'b0000001;
        #1;
        chk_out("b2b_err2_b", 1'b1, 1'b1, 32'h0);
        cyc();
        P_HSEL  = '0;
        HTRANS  = HTRANS_IDLE;
        P_HRESP = '0;
        set_slot(0, 32'h0000_A0A0);
        #1;
        chk_out("p0_after_errors", 1'b1, 1'b0, 32'h0000_A0A0);

        // Asynchronous reset during ERR1
        cyc();
        HTRANS = HTRANS_NONSEQ;
        cyc();
        HTRANS = HTRANS_IDLE;
        #1;
        chk_out("rst_err1_before", 1'b0, 1'b1, 32'h0);
        #1;
        HRESET = 1'b1;
        #1;
        chk_out("rst_err1_async", 1'b1, 1'b0, 32'h0);
        #2;
        HRESET = 1'b0;
        cyc();
        chk_out("rst_err1_after", 1'b1, 1'b0, 32'h0);

        // Asynchronous reset during a P5 wait state
        P_HSEL = 7'b0100000;
        HTRANS = HTRANS_NONSEQ;
        cyc();
        P_HSEL = '0;
        HTRANS = HTRANS_IDLE;
        P_HREADYOUT = 7'b1011111;
        set_slot(5, 32'h5555_5555);
        #1;
        chk_out("p5_wait", 1'b0, 1'b0, 32'h5555_5555);
        #1;
        HRESET = 1'b1;
        #1;
        chk_out("rst_p5_async", 1'b1, 1'b0, 32'h0);
        #2;
        HRESET = 1'b0;
        P_HREADYOUT = '1;
        cyc();
        chk_out("rst_p5_after", 1'b1, 1'b0, 32'h0);

        // P0 transfer after reset recovery
        P_HSEL = 7'b0000001;
        HTRANS = HTRANS_NONSEQ;
        cyc();
        P_HSEL = '0;
        HTRANS = HTRANS_IDLE;
        set_slot(0, 32'h600D_0000);
        #1;
        chk_out("p0_after_reset", 1'b1, 1'b0, 32'h600D_0000);
        cyc();
        chk_out("final_idle", 1'b1, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahblite_slave_mux.md
Name: ahblite_slave_mux

Overview:
- AHB-Lite data-phase response multiplexer directly downstream of the address decoder.
- Registers the decoder's per-port HSEL during the address phase and steers the selected slave's HRDATA, HREADYOUT and HRESP back to the master during the data phase.
- Contains a built-in default slave that returns the two-cycle AHB ERROR response for unmapped or disabled-port accesses.
- The combined HREADY output drives the master and is fed back to every slave and to this block's own HREADY input.

Parameters:
- PORT_NUM, 7, number of decoded slave ports (P0..P6).
- DW, 32, data bus width.
- ERR_RDATA, 32'h0000_0000, HRDATA value driven during a default-slave data phase.

Ports:
- HCLK  input  1  system clock; all state on rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- HREADY  input  1  bus HREADY fed back from this block's HREADY_OUT.
- HTRANS  input  2  master transfer type; only bit 1 (NONSEQ/SEQ) is used.
- P_HSEL  input  PORT_NUM  decoder selects, bit i = Pi_HSEL.
- P_HREADYOUT  input  PORT_NUM  per-slave HREADYOUT.
- P_HRESP  input  PORT_NUM  per-slave HRESP (1 = ERROR).
- P_HRDATA  input  PORT_NUM*DW  per-slave read data; slot i at bits [i*DW +: DW].
- HREADY_OUT  output  1  bus HREADY to the master and all slaves.
- HRESP  output  1  bus HRESP to the master.
- HRDATA  output  DW  bus read data to the master.

Behaviour:
- Address-phase decode:
  - def_sel = (P_HSEL == 0).
  - If more than one P_HSEL bit is set, the lowest index wins (one-hot forced).
- Data-phase select register sel_q, width PORT_NUM+1:
  - Bit PORT_NUM is the default slave.
  - Loaded with {def_sel & HTRANS[1], onehot(P_HSEL)} only when HREADY=1; held when HREADY=0.
  - Reset value is all-zero, meaning no data phase.
- Output mux (purely combinational from sel_q, P_* and the default-slave FSM; AND-OR one-hot):
  - sel_q == 0: HREADY_OUT=1, HRESP=0, HRDATA=0.
  - sel_q[i], i<PORT_NUM: outputs = P_HREADYOUT[i], P_HRESP[i], slot i of P_HRDATA.
  - sel_q[PORT_NUM]: outputs come from the default-slave FSM; HRDATA=ERR_RDATA.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: def_HREADYOUT=1, def_HRESP=0. On HREADY & def_sel & HTRANS[1] -> ERR1. Otherwise stay.
  - ERR1: def_HREADYOUT=0, def_HRESP=1. Unconditionally -> ERR2.
  - ERR2: def_HREADYOUT=1, def_HRESP=1. If HREADY & def_sel & HTRANS[1] (back-to-back unmapped) -> ERR1, else -> IDLE.
  - IDLE/BUSY transfers to unmapped space get a zero-wait OKAY: sel_q bit is not set and the FSM stays in IDLE.
- Latency:
  - Data phase begins one HCLK after an address phase accepted with HREADY=1.
  - Unmapped access costs exactly 2 data-phase cycles.
- Wait states: while the selected slave holds HREADYOUT=0, sel_q and the FSM hold, and P_HSEL changes are ignored.
- Slave ERROR passthrough: a slave's HRESP is forwarded cycle-for-cycle; its two-cycle sequence is the slave's responsibility.
- Reset:
  - Asserting HRESET at any time, including mid wait state or mid ERR1/ERR2, forces sel_q=0 and FSM=IDLE immediately.
  - Outputs go to HREADY_OUT=1, HRESP=0, HRDATA=0 without waiting for a clock edge.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HRESP_OKAY=0, HRESP_ERROR=1.
  - Default-slave state enum.
  - PORT_NUM default.
- One natural sub-module: ahblite_default_slave, containing the 3-state FSM. Its inputs are HCLK, HRESET, HREADY, HSEL (def_sel), HTRANS; its outputs are HREADYOUT and HRESP. The mux instantiates it once.

Test Plan:
- Reset: HRESET=1 with random P_* inputs -> HREADY_OUT=1, HRESP=0, HRDATA=0. Release, no transfer -> unchanged.
- Single read via P1: address phase P_HSEL=7'b0000010, HTRANS=NONSEQ, HREADY=1. Next cycle P_HRDATA slot1=32'h1234_5678, P_HREADYOUT[1]=1 -> HRDATA=32'h1234_5678, HREADY_OUT=1, HRESP=0.
- Wait states on P2: P_HREADYOUT[2]=0 for 3 cycles while P_HSEL switches to P4 -> HREADY_OUT=0 for 3 cycles, then P2 data returned. Next data phase is served by P4.
- Unmapped NONSEQ (P_HSEL=0): cycle 1 HREADY_OUT=0/HRESP=1, cycle 2 HREADY_OUT=1/HRESP=1, cycle 3 OKAY. Same address with HTRANS=IDLE -> zero-wait OKAY.
- Back-to-back unmapped NONSEQ presented during ERR2 -> pattern repeats with no OKAY cycle between. Then a mapped P0 access -> served normally.
- HRESET asserted during ERR1 and during a P5 wait state -> outputs go to reset values asynchronously. After release, the next P0 transfer completes correctly.
